axi_write_master: RTL and testbench
===================================

# axi_write_master

Single-client AXI4 write master: accepts a burst request (address, length) and a beat stream from a result producer, issues the AW burst, streams W beats with WLAST, and retires B responses. It sits beside the read arbiter in the accelerator top and drives the DDR3 port's write address, write data and write response channels. The top level ties off the burst constants (size, burst type, lock, cache, prot, qos, strobes).

## Interface
- ID_WIDTH, 8: AXI ID width.
- ADDR_WIDTH, 33: byte address width.
- DATA_WIDTH, 256: beat width (32 bytes).
- AXI_ID, 0: constant AWID value.
- MAX_OUTSTANDING, 4: maximum bursts awaiting a B response (power of 2, at least 2).

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- wr_addr_in  in  ADDR_WIDTH  burst start byte address.
- wr_len_in  in  8  beats minus 1 (AXI encoding).
- wr_info_valid_in  in  1  request valid.
- wr_info_rdy_out  out  1  request accepted when high with valid.
- wr_data_in  in  DATA_WIDTH  beat data.
- wr_data_valid_in  in  1  beat valid.
- wr_data_rdy_out  out  1  beat consumed when high with valid.
- wr_done_out  out  1  one-cycle pulse per retired B response.
- wr_err_out  out  1  sticky error flag.
- axi_awready_in  in  1; axi_awid_out  out  ID_WIDTH; axi_awaddr_out  out  ADDR_WIDTH; axi_awlen_out  out  8; axi_awvalid_out  out  1.
- axi_wready_in  in  1; axi_wdata_out  out  DATA_WIDTH; axi_wlast_out  out  1; axi_wvalid_out  out  1.
- axi_bid_in  in  ID_WIDTH; axi_bresp_in  in  2; axi_bvalid_in  in  1; axi_bready_out  out  1.

## Operation
- Registered `running` flag: 0 in reset, 1 from the first clk edge after reset release.
- FSM states:
  - IDLE: on request accept, go to ADDR.
  - ADDR: go to DATA on an AW handshake.
  - DATA: go to IDLE on the handshake of the beat with WLAST.
- wr_info_rdy_out = running & IDLE & (outstanding < MAX_OUTSTANDING).
- On accept, register the following:
  - addr with bits [4:0] forced to 0;
  - len_q;
  - beat_cnt = 0.
- In ADDR: axi_awvalid_out = 1. It is held with awaddr/awlen stable until awready is seen.
- W beats are issued only after their AW handshake. AW is never issued ahead of the previous burst's WLAST.
- DATA passthrough:
  - axi_wvalid_out = wr_data_valid_in;
  - wr_data_rdy_out = axi_wready_in;
  - axi_wdata_out = wr_data_in.
  - Outside DATA, wvalid and wr_data_rdy_out are 0.
- axi_wlast_out = DATA & (beat_cnt == len_q). beat_cnt increments on each W handshake.
- outstanding: 3-bit-min counter.
  - +1 on an AW handshake, −1 on a B handshake.
  - Both in the same cycle: unchanged.
  - Saturates at 0 on a stray B.
- axi_bready_out = running. wr_done_out pulses the cycle after each B handshake.
- Reset values:
  - awvalid, wvalid, wlast, bready, wr_info_rdy_out, wr_data_rdy_out, wr_done_out, wr_err_out: 0.
  - awaddr, awlen: 0.
  - State IDLE, outstanding 0.
- Reset mid-burst aborts immediately: every output returns to its reset value and the burst is not completed. The caller owns DDR consistency.
- Crossing a 4 KB boundary is the requester's responsibility and is not checked.

## Timing
- Request accepted at edge N; awvalid is high from N+1.
- If awready is already high, the AW handshake completes at N+1 and wvalid follows wr_data_valid_in from N+2.
- W path adds zero latency (combinational).
- Minimum burst of len+1 beats: accept to final WLAST is len+2 cycles. The next request can be accepted on the cycle after WLAST.
- B handshake at edge M gives wr_done_out high during M+1 and wr_info_rdy_out re-evaluated in M+1.

## Configuration
- AXI_WR_RESP_CHECK_EN defined:
  - wr_err_out sets on a B handshake with bresp ≠ OKAY (2'b00), bid ≠ AXI_ID, or outstanding == 0.
  - Clears only on rst.
- Not defined: wr_err_out is tied 0 and bresp/bid are ignored.

## Structure
- Package axi_wr_pkg holds:
  - the state enum (IDLE/ADDR/DATA);
  - RESP_OKAY = 2'b00;
  - BYTE_OFFSET_BITS = 5.
- Single module; the outstanding counter stays inline with no sub-module.

## Test plan
- Single burst: addr 0x1000_0013, len 3, data always valid, ready always high -> awaddr 0x1000_0000, awlen 3; 4 beats with wlast on beat 4; B OKAY -> wr_done_out pulses once.
- W back-pressure: len 7, wready toggled 1/0 each cycle -> 8 beats in order, no beats duplicated or dropped, wlast only on beat 8.
- Outstanding limit: 4 bursts of len 0 with bvalid held low -> wr_info_rdy_out goes 0 after the 4th AW. One B -> accepts the 5th.
- Simultaneous AW and B handshake in the same cycle -> outstanding unchanged; the 5th request is still blocked at MAX−1+1.
- With AXI_WR_RESP_CHECK_EN: bresp 2'b10 -> wr_err_out 1 and stays 1 through later OKAY responses. Without the macro: wr_err_out stays 0.
- rst asserted during beat 2 of a len 3 burst -> wvalid, awvalid and bready go 0 asynchronously. After release: IDLE, outstanding 0, wr_info_rdy_out 1 one cycle later.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared definitions for the AXI4 write master.
//   wr_state_e       : burst FSM state (IDLE -> ADDR -> DATA -> IDLE)
//   RESP_OKAY        : BRESP encoding for a clean response
//   BYTE_OFFSET_BITS : low address bits cleared to align bursts to a beat
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam int         BYTE_OFFSET_BITS = 5;

endpackage

// File: rtl/axi_write_master.sv
// Single-client AXI4 write master.
// Takes one burst request (address, beats-1) at a time from a result
// producer, issues AW, passes the producer's beat stream straight onto W
// with WLAST on the final beat, and retires B responses.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   wr_addr_in/wr_len_in         burst start byte address, beats minus 1
//   wr_info_valid_in/_rdy_out    request handshake
//   wr_data_in/_valid_in/_rdy_out beat stream from producer
//   wr_done_out                  one-cycle pulse per retired B response
//   wr_err_out                   sticky error flag
//   axi_aw*/axi_w*/axi_b*        AXI4 write address, data, response channels
//
// Build option: AXI_WR_RESP_CHECK_EN enables the sticky error flag (bad
// BRESP, unexpected BID, or a B with nothing outstanding). Without it
// wr_err_out is tied low and BID/BRESP are ignored.
module axi_write_master
    import axi_wr_pkg::*;
#(
    parameter int ID_WIDTH        = 8,
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [7:0]            wr_len_in,
    input  logic                  wr_info_valid_in,
    output logic                  wr_info_rdy_out,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic                  wr_data_valid_in,
    output logic                  wr_data_rdy_out,
    output logic                  wr_done_out,
    output logic                  wr_err_out,
    input  logic                  axi_awready_in,
    output logic [ID_WIDTH-1:0]   axi_awid_out,
    output logic [ADDR_WIDTH-1:0] axi_awaddr_out,
    output logic [7:0]            axi_awlen_out,
    output logic                  axi_awvalid_out,
    input  logic                  axi_wready_in,
    output logic [DATA_WIDTH-1:0] axi_wdata_out,
    output logic                  axi_wlast_out,
    output logic                  axi_wvalid_out,
    input  logic [ID_WIDTH-1:0]   axi_bid_in,
    input  logic [1:0]            axi_bresp_in,
    input  logic                  axi_bvalid_in,
    output logic                  axi_bready_out
);

    // Counter must hold MAX_OUTSTANDING itself, and is never narrower than 3 bits.
    localparam int OUT_W = ($clog2(MAX_OUTSTANDING) + 1 > 3) ? $clog2(MAX_OUTSTANDING) + 1 : 3;

    wr_state_e             state_q, state_d;
    logic                  running_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  done_q;

    logic aw_hs, w_hs, b_hs;
    logic info_rdy, awvalid, wvalid, wlast, data_rdy;

    assign aw_hs = awvalid & axi_awready_in;
    assign w_hs  = wvalid & axi_wready_in;
    assign b_hs  = axi_bvalid_in & axi_bready_out;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        data_rdy   = 1'b0;
        info_rdy   = running_q && (state_q == IDLE) &&
                     (outstanding_q < OUT_W'(MAX_OUTSTANDING));
        case (state_q)
            IDLE: begin
                if (wr_info_valid_in && info_rdy) begin
                    state_d    = ADDR;
                    addr_d     = {wr_addr_in[ADDR_WIDTH-1:BYTE_OFFSET_BITS],
                                  {BYTE_OFFSET_BITS{1'b0}}};
                    len_d      = wr_len_in;
                    beat_cnt_d = 8'd0;
                end
            end
            ADDR: begin
                awvalid = 1'b1;
                if (axi_awready_in) state_d = DATA;
            end
            DATA: begin
                // W is a straight combinational passthrough of the producer.
                wvalid   = wr_data_valid_in;
                data_rdy = axi_wready_in;
                wlast    = (beat_cnt_q == len_q);
                if (wr_data_valid_in && axi_wready_in) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (wlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous AW and B cancel; a stray B never wraps below zero.
    always_comb begin
        outstanding_d = outstanding_q;
        if (aw_hs && !b_hs)
            outstanding_d = outstanding_q + OUT_W'(1);
        else if (b_hs && !aw_hs && (outstanding_q != '0))
            outstanding_d = outstanding_q - OUT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            running_q     <= 1'b0;
            addr_q        <= '0;
            len_q         <= 8'd0;
            beat_cnt_q    <= 8'd0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            running_q     <= 1'b1;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            done_q        <= b_hs;
        end
    end

    assign wr_info_rdy_out = info_rdy;
    assign wr_data_rdy_out = data_rdy;
    assign wr_done_out     = done_q;
    assign axi_awid_out    = ID_WIDTH'(AXI_ID);
    assign axi_awaddr_out  = addr_q;
    assign axi_awlen_out   = len_q;
    assign axi_awvalid_out = awvalid;
    assign axi_wdata_out   = wr_data_in;
    assign axi_wlast_out   = wlast;
    assign axi_wvalid_out  = wvalid;
    assign axi_bready_out  = running_q;

`ifdef AXI_WR_RESP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (b_hs && ((axi_bresp_in != RESP_OKAY) ||
                     (axi_bid_in != ID_WIDTH'(AXI_ID)) ||
                     (outstanding_q == '0)))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign wr_err_out = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{axi_bid_in, axi_bresp_in};
    assign wr_err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_master.sv
// Directed bench for axi_write_master: single burst, W back-pressure,
// outstanding limit with a simultaneous AW/B, response error flag, and
// reset in the middle of a burst.
module tb_axi_write_master;
    import axi_wr_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [32:0]  wr_addr_in;
    logic [7:0]   wr_len_in;
    logic         wr_info_valid_in;
    logic         wr_info_rdy_out;
    logic [255:0] wr_data_in;
    logic         wr_data_valid_in;
    logic         wr_data_rdy_out;
    logic         wr_done_out;
    logic         wr_err_out;
    logic         axi_awready_in;
    logic [7:0]   axi_awid_out;
    logic [32:0]  axi_awaddr_out;
    logic [7:0]   axi_awlen_out;
    logic         axi_awvalid_out;
    logic         axi_wready_in;
    logic [255:0] axi_wdata_out;
    logic         axi_wlast_out;
    logic         axi_wvalid_out;
    logic [7:0]   axi_bid_in;
    logic [1:0]   axi_bresp_in;
    logic         axi_bvalid_in;
    logic         axi_bready_out;

    axi_write_master dut (
        .clk(clk), .rst(rst),
        .wr_addr_in(wr_addr_in), .wr_len_in(wr_len_in),
        .wr_info_valid_in(wr_info_valid_in), .wr_info_rdy_out(wr_info_rdy_out),
        .wr_data_in(wr_data_in), .wr_data_valid_in(wr_data_valid_in),
        .wr_data_rdy_out(wr_data_rdy_out),
        .wr_done_out(wr_done_out), .wr_err_out(wr_err_out),
        .axi_awready_in(axi_awready_in), .axi_awid_out(axi_awid_out),
        .axi_awaddr_out(axi_awaddr_out), .axi_awlen_out(axi_awlen_out),
        .axi_awvalid_out(axi_awvalid_out),
        .axi_wready_in(axi_wready_in), .axi_wdata_out(axi_wdata_out),
        .axi_wlast_out(axi_wlast_out), .axi_wvalid_out(axi_wvalid_out),
        .axi_bid_in(axi_bid_in), .axi_bresp_in(axi_bresp_in),
        .axi_bvalid_in(axi_bvalid_in), .axi_bready_out(axi_bready_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int w_hs_cnt = 0;
    int done_cnt = 0;
    logic [31:0]  seq = 32'd0;
    bit           toggle_en = 1'b0;
    bit           err_exp;
    logic [255:0] wd [0:255];
    bit           wl [0:255];

    assign wr_data_in = {8{32'hA500_0000 | seq}};

    function automatic logic [255:0] beat_data(input int k);
        logic [31:0] w;
        w = 32'hA500_0000 | k;
        return {8{w}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Record handshakes mid-cycle, where inputs and state are settled.
    always @(negedge clk) begin
        if (axi_wvalid_out && axi_wready_in) begin
            wd[w_hs_cnt[7:0]] = axi_wdata_out;
            wl[w_hs_cnt[7:0]] = axi_wlast_out;
            w_hs_cnt++;
        end
        if (wr_done_out) done_cnt++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (toggle_en) axi_wready_in = ~axi_wready_in;
        seq = w_hs_cnt;
    endtask

    task automatic wait_beats(input int target, input int budget, output int n);
        n = 0;
        while (w_hs_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        if (w_hs_cnt < target) chk("beat_timeout", w_hs_cnt, target);
    endtask

    task automatic b_pulse(input logic [1:0] resp);
        axi_bvalid_in = 1'b1;
        axi_bresp_in  = resp;
        cycle();
        axi_bvalid_in = 1'b0;
        axi_bresp_in  = RESP_OKAY;
        chk("done_pulse", wr_done_out, 1'b1);
    endtask

    task automatic do_burst(input logic [32:0] a, input logic [7:0] l);
        int n, base;
        n = 0;
        while (!wr_info_rdy_out && n < 20) begin cycle(); n++; end
        if (!wr_info_rdy_out) chk("rdy_timeout", wr_info_rdy_out, 1'b1);
        base = w_hs_cnt;
        wr_addr_in = a; wr_len_in = l; wr_info_valid_in = 1'b1;
        cycle();
        wr_info_valid_in = 1'b0;
        wait_beats(base + int'(l) + 1, 40, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int n, base;
`ifdef AXI_WR_RESP_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        rst = 1'b1;
        wr_addr_in = '0; wr_len_in = '0; wr_info_valid_in = 1'b0;
        wr_data_valid_in = 1'b0;
        axi_awready_in = 1'b1; axi_wready_in = 1'b1;
        axi_bid_in = '0; axi_bresp_in = RESP_OKAY; axi_bvalid_in = 1'b0;
        cycle(); cycle();

        // reset state
        chk("rst_awvalid", axi_awvalid_out, 1'b0);
        chk("rst_wvalid", axi_wvalid_out, 1'b0);
        chk("rst_wlast", axi_wlast_out, 1'b0);
        chk("rst_bready", axi_bready_out, 1'b0);
        chk("rst_info_rdy", wr_info_rdy_out, 1'b0);
        chk("rst_data_rdy", wr_data_rdy_out, 1'b0);
        chk("rst_done", wr_done_out, 1'b0);
        chk("rst_err", wr_err_out, 1'b0);
        chk("rst_awaddr", axi_awaddr_out, 33'h0);
        chk("rst_awlen", axi_awlen_out, 8'h0);

        rst = 1'b0;
        chk("run_rdy_early", wr_info_rdy_out, 1'b0);
        cycle();
        chk("run_rdy", wr_info_rdy_out, 1'b1);
        chk("run_bready", axi_bready_out, 1'b1);

        // single burst, len 3, unaligned address
        base = w_hs_cnt;
        wr_addr_in = 33'h1000_0013; wr_len_in = 8'd3;
        wr_info_valid_in = 1'b1; wr_data_valid_in = 1'b1;
        cycle();
        wr_info_valid_in = 1'b0;
        chk("t1_awvalid", axi_awvalid_out, 1'b1);
        chk("t1_awaddr", axi_awaddr_out, 33'h1000_0000);
        chk("t1_awlen", axi_awlen_out, 8'd3);
        chk("t1_awid", axi_awid_out, 8'd0);
        chk("t1_wvalid_pre_aw", axi_wvalid_out, 1'b0);
        wait_beats(base + 4, 20, n);
        chk("t1_latency", n, 5);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", wd[base + i], beat_data(base + i));
            chk("t1_wlast", wl[base + i], i == 3);
        end
        chk("t1_rdy_after_last", wr_info_rdy_out, 1'b1);
        wr_data_valid_in = 1'b0;
        b_pulse(RESP_OKAY);
        cycle();
        chk("t1_done_once", wr_done_out, 1'b0);
        chk("t1_done_cnt", done_cnt, 1);

        // W back-pressure, len 7, wready toggling
        base = w_hs_cnt;
        wr_addr_in = 33'h0_2000_0040; wr_len_in = 8'd7;
        wr_info_valid_in = 1'b1; wr_data_valid_in = 1'b1;
        cycle();
        wr_info_valid_in = 1'b0;
        toggle_en = 1'b1;
        wait_beats(base + 8, 60, n);
        toggle_en = 1'b0; axi_wready_in = 1'b1;
        cycle(); cycle();
        chk("t2_beat_count", w_hs_cnt - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_data", wd[base + i], beat_data(base + i));
            chk("t2_wlast", wl[base + i], i == 7);
        end
        // SLVERR response: flags only when response checking is built in
        b_pulse(2'b10);
        chk("t2_err", wr_err_out, err_exp);

        // outstanding limit: 4 len-0 bursts with no B
        for (int k = 0; k < 4; k++) do_burst(33'h0_3000_0000 + 33'(k * 32), 8'd0);
        chk("t3_outst4", dut.outstanding_q, 3'd4);
        wr_addr_in = 33'h0_4000_0000; wr_len_in = 8'd0; wr_info_valid_in = 1'b1;
        cycle(); cycle(); cycle();
        chk("t3_blocked_rdy", wr_info_rdy_out, 1'b0);
        chk("t3_blocked_aw", axi_awvalid_out, 1'b0);
        axi_awready_in = 1'b0;
        b_pulse(RESP_OKAY);
        chk("t3_rdy_after_b", wr_info_rdy_out, 1'b1);
        chk("t3_outst3", dut.outstanding_q, 3'd3);
        cycle();
        wr_info_valid_in = 1'b0;
        chk("t3_5th_aw", axi_awvalid_out, 1'b1);
        // AW and B handshake on the same edge
        base = w_hs_cnt;
        axi_awready_in = 1'b1;
        b_pulse(RESP_OKAY);
        chk("t4_outst_same", dut.outstanding_q, 3'd3);
        wait_beats(base + 1, 10, n);
        chk("t4_rdy", wr_info_rdy_out, 1'b1);
        do_burst(33'h0_5000_0000, 8'd0);
        chk("t4_outst_full", dut.outstanding_q, 3'd4);
        chk("t4_blocked", wr_info_rdy_out, 1'b0);
        wr_data_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) b_pulse(RESP_OKAY);
        chk("t4_drained", dut.outstanding_q, 3'd0);
        b_pulse(RESP_OKAY);
        chk("t4_stray_sat", dut.outstanding_q, 3'd0);
        chk("t4_err_sticky", wr_err_out, err_exp);
        cycle();
        chk("t4_done_cnt", done_cnt, 9);

        // reset during beat 2 of a len 3 burst
        wr_addr_in = 33'h0_6000_0000; wr_len_in = 8'd3;
        wr_info_valid_in = 1'b1; wr_data_valid_in = 1'b1;
        cycle();
        wr_info_valid_in = 1'b0;
        cycle();
        cycle();
        chk("t5_in_burst", axi_wvalid_out, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_wvalid", axi_wvalid_out, 1'b0);
        chk("t5_rst_awvalid", axi_awvalid_out, 1'b0);
        chk("t5_rst_bready", axi_bready_out, 1'b0);
        chk("t5_rst_wlast", axi_wlast_out, 1'b0);
        chk("t5_rst_err", wr_err_out, 1'b0);
        wr_data_valid_in = 1'b0;
        cycle();
        rst = 1'b0;
        chk("t5_state", dut.state_q, IDLE);
        chk("t5_outst", dut.outstanding_q, 3'd0);
        chk("t5_rdy_early", wr_info_rdy_out, 1'b0);
        cycle();
        chk("t5_rdy", wr_info_rdy_out, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
